// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: data/register widths,
// memory-operation encodings, MEM FSM state codes and lane helper functions.
package mem_stage_pkg;

  localparam int WORD_DATA_W = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int MEM_OP_W    = 4;
  localparam int WORD_ADDR_W = 30;

  // Memory operation encodings carried down the pipeline from decode.
  typedef enum logic [MEM_OP_W-1:0] {
    MEM_OP_NOP = 4'd0,
    MEM_OP_LW  = 4'd1,
    MEM_OP_LH  = 4'd2,
    MEM_OP_LHU = 4'd3,
    MEM_OP_LB  = 4'd4,
    MEM_OP_LBU = 4'd5,
    MEM_OP_SW  = 4'd6,
    MEM_OP_SH  = 4'd7,
    MEM_OP_SB  = 4'd8
  } mem_op_e;

  // MEM stage FSM: IDLE issues/holds the bus request, DONE waits for the
  // controller to let the MEM/WB register take the finished result.
  typedef enum logic [0:0] {
    MEM_ST_IDLE = 1'b0,
    MEM_ST_DONE = 1'b1
  } mem_state_e;

  function automatic logic [WORD_DATA_W-1:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [WORD_DATA_W-1:0] zext8(input logic [7:0] b);
    return {24'h000000, b};
  endfunction

  function automatic logic [WORD_DATA_W-1:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

  function automatic logic [WORD_DATA_W-1:0] zext16(input logic [15:0] h);
    return {16'h0000, h};
  endfunction

  // Byte enables of the half-word selected by address bit 1.
  function automatic logic [3:0] half_be(input logic upper);
    return upper ? 4'b1100 : 4'b0011;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Lane alignment for the MEM stage: byte enables, store-data replication,
// load extract with sign/zero extension and misalignment detection.
// Optional feature: MEM_MISALIGN_EXC_EN enables misalignment detection;
// without it the low address bits are ignored and misalign is tied 0.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [MEM_OP_W-1:0]    op,
  input  logic [1:0]             addr_lo,
  input  logic [WORD_DATA_W-1:0] wr_data,
  input  logic [WORD_DATA_W-1:0] rd_word,
  output logic                   is_mem,
  output logic                   is_load,
  output logic                   rw,
  output logic [3:0]             be,
  output logic [WORD_DATA_W-1:0] wr_lanes,
  output logic [WORD_DATA_W-1:0] rd_ext,
  output logic                   misalign
);

  mem_op_e     op_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign op_s   = mem_op_e'(op);
  assign byte_s = rd_word[{addr_lo, 3'b000} +: 8];
  assign half_s = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
  assign is_mem = is_load | rw;

  // Decode the operation into direction, lane enables and aligned data.
  always_comb begin
    is_load  = 1'b0;
    rw       = 1'b0;
    be       = 4'b0000;
    wr_lanes = {WORD_DATA_W{1'b0}};
    rd_ext   = rd_word;
    case (op_s)
      MEM_OP_LW:  begin is_load = 1'b1; be = 4'b1111; rd_ext = rd_word; end
      MEM_OP_LH:  begin is_load = 1'b1; be = half_be(addr_lo[1]); rd_ext = sext16(half_s); end
      MEM_OP_LHU: begin is_load = 1'b1; be = half_be(addr_lo[1]); rd_ext = zext16(half_s); end
      MEM_OP_LB:  begin is_load = 1'b1; be = 4'b0001 << addr_lo; rd_ext = sext8(byte_s); end
      MEM_OP_LBU: begin is_load = 1'b1; be = 4'b0001 << addr_lo; rd_ext = zext8(byte_s); end
      MEM_OP_SW:  begin rw = 1'b1; be = 4'b1111; wr_lanes = wr_data; end
      MEM_OP_SH:  begin rw = 1'b1; be = half_be(addr_lo[1]); wr_lanes = {2{wr_data[15:0]}}; end
      MEM_OP_SB:  begin rw = 1'b1; be = 4'b0001 << addr_lo; wr_lanes = {4{wr_data[7:0]}}; end
      MEM_OP_NOP: begin end
      default:    begin end
    endcase
  end

`ifdef MEM_MISALIGN_EXC_EN
  // Flag word accesses off a word boundary and half accesses off a half boundary.
  always_comb begin
    misalign = 1'b0;
    case (op_s)
      MEM_OP_LW, MEM_OP_SW:              misalign = |addr_lo;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH:  misalign = addr_lo[0];
      default:                           misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline: one data-bus access per load/store,
// busy towards the pipeline controller until the access completes, and the
// MEM/WB pipeline register.
// Optional feature: MEM_MISALIGN_EXC_EN turns misaligned accesses into an
// exception (no bus request, mem_exp=1) instead of forcing them aligned.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   ex_en,
  input  logic [MEM_OP_W-1:0]    ex_mem_op,
  input  logic [WORD_DATA_W-1:0] ex_mem_wr_data,
  input  logic [REG_ADDR_W-1:0]  ex_dst_addr,
  input  logic                   ex_gpr_we_,
  input  logic [WORD_DATA_W-1:0] ex_out,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy,
  output logic                   bus_req,
  output logic                   bus_rw,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic [3:0]             bus_be,
  output logic [WORD_DATA_W-1:0] bus_wr_data,
  output logic                   busy,
  output logic                   mem_en,
  output logic [REG_ADDR_W-1:0]  mem_dst_addr,
  output logic                   mem_gpr_we_,
  output logic [WORD_DATA_W-1:0] mem_out,
  output logic                   mem_exp
);

  mem_state_e            state_r;
  mem_state_e            state_nxt_s;
  logic [WORD_DATA_W-1:0] rd_buf_r;

  logic                   is_mem_s;
  logic                   is_load_s;
  logic                   rw_s;
  logic [3:0]             be_s;
  logic [WORD_DATA_W-1:0] wr_lanes_s;
  logic [WORD_DATA_W-1:0] rd_ext_s;
  logic                   misalign_raw_s;
  logic                   misalign_s;
  logic                   mem_op_s;
  logic                   req_s;
  logic                   busy_s;
  logic                   load_s;
  logic                   req_out_s;
  logic [WORD_DATA_W-1:0] result_s;
  logic                   gpr_we_n_s;

  mem_align u_align (
    .op       (ex_mem_op),
    .addr_lo  (ex_out[1:0]),
    .wr_data  (ex_mem_wr_data),
    .rd_word  (rd_buf_r),
    .is_mem   (is_mem_s),
    .is_load  (is_load_s),
    .rw       (rw_s),
    .be       (be_s),
    .wr_lanes (wr_lanes_s),
    .rd_ext   (rd_ext_s),
    .misalign (misalign_raw_s)
  );

  // A misaligned access only counts for a valid entry; it never reaches the bus.
  assign misalign_s = ex_en & misalign_raw_s;
  assign mem_op_s   = ex_en & is_mem_s & ~misalign_s;

  // Next state, bus request/busy and MEM/WB load strobe.
  always_comb begin
    state_nxt_s = state_r;
    req_s       = 1'b0;
    busy_s      = 1'b0;
    load_s      = 1'b0;
    case (state_r)
      MEM_ST_IDLE: begin
        if (mem_op_s) begin
          req_s  = 1'b1;
          busy_s = 1'b1;
          if (bus_rdy) begin
            state_nxt_s = MEM_ST_DONE;
          end else begin
            state_nxt_s = MEM_ST_IDLE;
          end
        end else begin
          load_s      = ~stall;
          state_nxt_s = MEM_ST_IDLE;
        end
      end
      MEM_ST_DONE: begin
        load_s = ~stall;
        if (stall) begin
          state_nxt_s = MEM_ST_DONE;
        end else begin
          state_nxt_s = MEM_ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = MEM_ST_IDLE;
      end
    endcase
  end

  // Reset must drop the request immediately, even mid-access.
  assign req_out_s   = req_s & ~reset;
  assign bus_req     = req_out_s;
  assign busy        = busy_s & ~reset;
  assign bus_rw      = req_out_s & rw_s;
  assign bus_addr    = req_out_s ? ex_out[WORD_DATA_W-1:2] : {WORD_ADDR_W{1'b0}};
  assign bus_be      = req_out_s ? be_s : 4'b0000;
  assign bus_wr_data = req_out_s ? wr_lanes_s : {WORD_DATA_W{1'b0}};

  // Select the value and write enable presented to MEM/WB.
  always_comb begin
    result_s   = ex_out;
    gpr_we_n_s = ex_gpr_we_;
    if (mem_op_s && is_load_s) begin
      result_s = rd_ext_s;
    end else begin
      result_s = ex_out;
    end
    if (misalign_s) begin
      gpr_we_n_s = 1'b1;
    end else begin
      gpr_we_n_s = ex_gpr_we_;
    end
  end

  // FSM state register and capture of the read data on bus completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= MEM_ST_IDLE;
      rd_buf_r <= {WORD_DATA_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (req_s && bus_rdy) begin
        rd_buf_r <= bus_rd_data;
      end else begin
        rd_buf_r <= rd_buf_r;
      end
    end
  end

  // MEM/WB pipeline register: flush clears it, otherwise it takes the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en       <= 1'b0;
      mem_dst_addr <= {REG_ADDR_W{1'b0}};
      mem_gpr_we_  <= 1'b1;
      mem_out      <= {WORD_DATA_W{1'b0}};
      mem_exp      <= 1'b0;
    end else if (load_s) begin
      if (flush) begin
        mem_en       <= 1'b0;
        mem_dst_addr <= {REG_ADDR_W{1'b0}};
        mem_gpr_we_  <= 1'b1;
        mem_out      <= {WORD_DATA_W{1'b0}};
        mem_exp      <= 1'b0;
      end else begin
        mem_en       <= ex_en;
        mem_dst_addr <= ex_dst_addr;
        mem_gpr_we_  <= gpr_we_n_s;
        mem_out      <= result_s;
        mem_exp      <= misalign_s;
      end
    end else begin
      mem_en       <= mem_en;
      mem_dst_addr <= mem_dst_addr;
      mem_gpr_we_  <= mem_gpr_we_;
      mem_out      <= mem_out;
      mem_exp      <= mem_exp;
    end
  end

endmodule
